// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM state encoding and counter sizing for the MD unit
package muldiv_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int m;
        m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// rtl/muldiv_hilo_if.sv - operand/control and HI/LO result bundle between EX stage and MD unit
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op, a, b, flush,
        input  start, busy, result, hi, lo
    );

    modport slave (
        input  op, a, b, flush,
        output start, busy, result, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle MULT/DIV unit with HI/LO registers; MULTDIV_MADD_EN enables MADD/MSUB ops
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_hilo_if.slave  md
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic               sh_we_q, sh_we_d;
    logic               start;

    logic               is_mul, is_div, mul_signed, div_signed;
`ifdef MULTDIV_MADD_EN
    logic               acc_add, acc_sub;
`endif
    logic [2*WIDTH-1:0] prod_s, prod_u, prod, mul_res;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
`ifdef MULTDIV_MADD_EN
        acc_add    = 1'b0;
        acc_sub    = 1'b0;
`endif
        case (md.op)
            MD_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            MD_MULTU: is_mul = 1'b1;
            MD_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
            MD_DIVU:  is_div = 1'b1;
`ifdef MULTDIV_MADD_EN
            MD_MADD:  begin is_mul = 1'b1; mul_signed = 1'b1; acc_add = 1'b1; end
            MD_MADDU: begin is_mul = 1'b1; acc_add = 1'b1; end
            MD_MSUB:  begin is_mul = 1'b1; mul_signed = 1'b1; acc_sub = 1'b1; end
            MD_MSUBU: begin is_mul = 1'b1; acc_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Low 2W bits of a sign-extended product equal the signed product.
    assign prod_s = {{WIDTH{md.a[WIDTH-1]}}, md.a} * {{WIDTH{md.b[WIDTH-1]}}, md.b};
    assign prod_u = {{WIDTH{1'b0}}, md.a} * {{WIDTH{1'b0}}, md.b};
    assign prod   = mul_signed ? prod_s : prod_u;

`ifdef MULTDIV_MADD_EN
    always_comb begin
        mul_res = prod;
        if (acc_add)
            mul_res = {hi_q, lo_q} + prod;
        else if (acc_sub)
            mul_res = {hi_q, lo_q} - prod;
    end
`else
    assign mul_res = prod;
`endif

    // Magnitude division; MIN/-1 falls out as MIN with zero remainder.
    assign a_neg   = div_signed & md.a[WIDTH-1];
    assign b_neg   = div_signed & md.b[WIDTH-1];
    assign mag_a   = a_neg ? -md.a : md.a;
    assign mag_b   = b_neg ? -md.b : md.b;
    assign divisor = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign q_mag   = mag_a / divisor;
    assign r_mag   = mag_a % divisor;
    assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem     = a_neg ? -r_mag : r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            sh_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_we_q <= sh_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_we_d = sh_we_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!md.flush) begin
                    if (is_mul) begin
                        start              = 1'b1;
                        state_d            = ST_MUL;
                        cnt_d              = CW'(MULT_CYCLES);
                        {sh_hi_d, sh_lo_d} = mul_res;
                        sh_we_d            = 1'b1;
                    end else if (is_div) begin
                        start   = 1'b1;
                        state_d = ST_DIV;
                        cnt_d   = CW'(DIV_CYCLES);
                        sh_hi_d = rem;
                        sh_lo_d = quot;
                        sh_we_d = (md.b != '0);
                    end else if (md.op == MD_MTHI) begin
                        hi_d = md.a;
                    end else if (md.op == MD_MTLO) begin
                        lo_d = md.a;
                    end
                end
            end
            default: begin
                // Flush beats the final count so an aborted op never commits.
                if (md.flush || cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!md.flush && sh_we_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    assign md.start  = start;
    assign md.busy   = (state_q != ST_IDLE);
    assign md.result = (md.op == MD_MFHI) ? hi_q :
                       (md.op == MD_MFLO) ? lo_q : '0;
    assign md.hi     = hi_q;
    assign md.lo     = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - randomized self-checking bench for muldiv_hilo against an arithmetic model
module tb_muldiv_hilo;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                           OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MTHI = 4'd5,
                           OP_MTLO = 4'd6, OP_MFHI = 4'd7, OP_MFLO = 4'd8,
                           OP_MADD = 4'd9, OP_MADDU = 4'd10, OP_MSUB = 4'd11,
                           OP_MSUBU = 4'd12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_hilo_if #(.WIDTH(W)) md();

    muldiv_hilo #(
        .WIDTH(W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .md(md)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi, m_lo;

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] hl);
        longint sp;
        logic [63:0] up;
        int q, r;
        sp = longint'(int'(x)) * longint'(int'(y));
        up = {32'b0, x} * {32'b0, y};
        case (o)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_DIV: begin
                if (y == 0) return hl;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = int'(x) / int'(y);
                r = int'(x) % int'(y);
                return {r, q};
            end
            OP_DIVU: begin
                if (y == 0) return hl;
                return {x % y, x / y};
            end
            OP_MADD:  return hl + sp;
            OP_MADDU: return hl + up;
            OP_MSUB:  return hl - sp;
            OP_MSUBU: return hl - up;
            default:  return hl;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
        return (o == OP_DIV || o == OP_DIVU) ? DC : MC;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic st, output int nb);
        md.op = o; md.a = x; md.b = y; md.flush = 1'b0;
        #1 st = md.start;
        @(posedge clk); #1;
        md.op = OP_NONE;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (!md.busy) break;
            nb++;
            @(posedge clk); #1;
        end
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] x);
        md.op = o; md.a = x;
        @(posedge clk); #1;
        md.op = OP_NONE;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        checks += 4;
        if (md.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", md.busy); end
        if (md.start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", md.start); end
        if (md.hi !== 32'h0 || md.lo !== 32'h0) begin
            failures++; $display("FAIL reset_hilo got=%h:%h exp=0:0", md.hi, md.lo);
        end
        if (md.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", md.result); end
    endtask

    task automatic test_flush;
        md.op = OP_MULT; md.a = 32'd6; md.b = 32'd7;
        #1 checks++;
        if (md.start !== 1'b1) begin failures++; $display("FAIL flush_start got=%b exp=1", md.start); end
        @(posedge clk); #1 md.op = OP_NONE;
        repeat (2) begin @(posedge clk); #1; end
        md.flush = 1'b1;
        checks++;
        if (md.busy !== 1'b1) begin failures++; $display("FAIL flush_busy3 got=%b exp=1", md.busy); end
        @(posedge clk); #1 md.flush = 1'b0;
        checks += 2;
        if (md.busy !== 1'b0) begin failures++; $display("FAIL flush_busy_after got=%b exp=0", md.busy); end
        if (md.hi !== m_hi || md.lo !== m_lo) begin
            failures++; $display("FAIL flush_hilo got=%h:%h exp=%h:%h", md.hi, md.lo, m_hi, m_lo);
        end
        md.op = OP_MULTU; md.a = 32'd9; md.b = 32'd9; md.flush = 1'b1;
        #1 checks++;
        if (md.start !== 1'b0) begin failures++; $display("FAIL flush_idle_start got=%b exp=0", md.start); end
        @(posedge clk); #1 md.op = OP_NONE; md.flush = 1'b0;
        checks++;
        if (md.busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy got=%b exp=0", md.busy); end
        // Abort on the final count.
        md.op = OP_MULT; md.a = 32'd11; md.b = 32'd13;
        @(posedge clk); #1 md.op = OP_NONE;
        repeat (MC - 1) begin @(posedge clk); #1; end
        md.flush = 1'b1;
        @(posedge clk); #1 md.flush = 1'b0;
        checks += 2;
        if (md.busy !== 1'b0) begin failures++; $display("FAIL flush_last_busy got=%b exp=0", md.busy); end
        if (md.hi !== m_hi || md.lo !== m_lo) begin
            failures++; $display("FAIL flush_last_hilo got=%h:%h exp=%h:%h", md.hi, md.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_mult;
        logic [3:0] o; logic [31:0] x, y; logic st; int nb;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin o = OP_MULT; x = 32'hFFFF_FFFD; y = 32'd5; end
            else begin
                o = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
                x = $urandom; y = $urandom;
            end
            {m_hi, m_lo} = model(o, x, y, {m_hi, m_lo});
            issue(o, x, y, st, nb);
            checks += 3;
            if (st !== 1'b1) begin failures++; $display("FAIL mult_start[%0d] got=%b exp=1", i, st); end
            if (nb != MC) begin failures++; $display("FAIL mult_busy[%0d] got=%0d exp=%0d", i, nb, MC); end
            if (md.hi !== m_hi || md.lo !== m_lo) begin
                failures++; $display("FAIL mult_hilo[%0d] op=%0d a=%h b=%h got=%h:%h exp=%h:%h",
                                     i, o, x, y, md.hi, md.lo, m_hi, m_lo);
            end
        end
        md.op = OP_MFLO;
        #1 checks++;
        if (md.result !== m_lo) begin failures++; $display("FAIL mflo got=%h exp=%h", md.result, m_lo); end
        md.op = OP_MFHI;
        #1 checks++;
        if (md.result !== m_hi) begin failures++; $display("FAIL mfhi got=%h exp=%h", md.result, m_hi); end
        md.op = OP_NONE;
    endtask

    task automatic test_div;
        logic [3:0] o; logic [31:0] x, y; logic st; int nb;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin o = OP_DIVU; x = 32'd17; y = 32'd5; end
                1: begin o = OP_DIV; x = 32'hFFFF_FFF9; y = 32'd2; end
                2: begin o = OP_DIV; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                default: begin
                    o = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
                    x = $urandom;
                    y = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 28);
                end
            endcase
            {m_hi, m_lo} = model(o, x, y, {m_hi, m_lo});
            issue(o, x, y, st, nb);
            checks += 3;
            if (st !== 1'b1) begin failures++; $display("FAIL div_start[%0d] got=%b exp=1", i, st); end
            if (nb != DC) begin failures++; $display("FAIL div_busy[%0d] got=%0d exp=%0d", i, nb, DC); end
            if (md.hi !== m_hi || md.lo !== m_lo) begin
                failures++; $display("FAIL div_hilo[%0d] op=%0d a=%h b=%h got=%h:%h exp=%h:%h",
                                     i, o, x, y, md.hi, md.lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_div_zero;
        logic st; int nb;
        mt(OP_MTHI, 32'h1234); m_hi = 32'h1234;
        checks++;
        if (md.hi !== 32'h1234) begin failures++; $display("FAIL mthi got=%h exp=1234", md.hi); end
        mt(OP_MTLO, 32'h5678); m_lo = 32'h5678;
        checks++;
        if (md.lo !== 32'h5678) begin failures++; $display("FAIL mtlo got=%h exp=5678", md.lo); end
        issue(OP_DIV, 32'd99, 32'd0, st, nb);
        checks += 2;
        if (nb != DC) begin failures++; $display("FAIL divzero_busy got=%0d exp=%0d", nb, DC); end
        if (md.hi !== 32'h1234 || md.lo !== 32'h5678) begin
            failures++; $display("FAIL divzero_hilo got=%h:%h exp=1234:5678", md.hi, md.lo);
        end
    endtask

    task automatic test_busy_ignore;
        int nb;
        md.op = OP_DIVU; md.a = 32'd100; md.b = 32'd7;
        {m_hi, m_lo} = model(OP_DIVU, 32'd100, 32'd7, {m_hi, m_lo});
        @(posedge clk); #1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4) begin md.op = OP_MULT; md.a = 32'd3; md.b = 32'd3; end
            else md.op = OP_NONE;
            #1;
            if (i < 4) begin
                checks++;
                if (md.start !== 1'b0) begin failures++; $display("FAIL ignore_start[%0d] got=%b exp=0", i, md.start); end
            end
            if (!md.busy) break;
            nb++;
            @(posedge clk); #1;
        end
        md.op = OP_NONE;
        checks += 2;
        if (nb != DC) begin failures++; $display("FAIL ignore_busy got=%0d exp=%0d", nb, DC); end
        if (md.hi !== m_hi || md.lo !== m_lo) begin
            failures++; $display("FAIL ignore_hilo got=%h:%h exp=%h:%h", md.hi, md.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid;
        mt(OP_MTHI, 32'h55); mt(OP_MTLO, 32'h66);
        md.op = OP_DIV; md.a = 32'd1000; md.b = 32'd3;
        @(posedge clk); #1 md.op = OP_NONE;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        checks += 2;
        if (md.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", md.busy); end
        if (md.hi !== 32'h0 || md.lo !== 32'h0) begin
            failures++; $display("FAIL rstmid_hilo got=%h:%h exp=0:0", md.hi, md.lo);
        end
        repeat (DC) begin @(posedge clk); #1; end
        checks++;
        if (md.hi !== 32'h0 || md.lo !== 32'h0) begin
            failures++; $display("FAIL rstmid_late_hilo got=%h:%h exp=0:0", md.hi, md.lo);
        end
    endtask

    task automatic test_madd;
`ifdef MULTDIV_MADD_EN
        logic [3:0] o; logic [31:0] x, y; logic st; int nb;
        mt(OP_MTHI, 32'h0); mt(OP_MTLO, 32'd10);
        m_hi = 32'h0; m_lo = 32'd10;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin o = OP_MADD; x = 32'd3; y = 32'd4; end
                1: begin o = OP_MSUBU; x = 32'd1; y = 32'd30; end
                default: begin
                    o = 4'(OP_MADD + $urandom_range(0, 3));
                    x = $urandom; y = $urandom;
                end
            endcase
            {m_hi, m_lo} = model(o, x, y, {m_hi, m_lo});
            issue(o, x, y, st, nb);
            checks += 3;
            if (st !== 1'b1) begin failures++; $display("FAIL madd_start[%0d] got=%b exp=1", i, st); end
            if (nb != MC) begin failures++; $display("FAIL madd_busy[%0d] got=%0d exp=%0d", i, nb, MC); end
            if (md.hi !== m_hi || md.lo !== m_lo) begin
                failures++; $display("FAIL madd_hilo[%0d] op=%0d got=%h:%h exp=%h:%h",
                                     i, o, md.hi, md.lo, m_hi, m_lo);
            end
        end
`else
        mt(OP_MTHI, 32'h11); mt(OP_MTLO, 32'h22);
        m_hi = 32'h11; m_lo = 32'h22;
        for (int o = 9; o <= 12; o++) begin
            md.op = 4'(o); md.a = $urandom; md.b = $urandom;
            #1 checks++;
            if (md.start !== 1'b0) begin failures++; $display("FAIL nomadd_start[%0d] got=%b exp=0", o, md.start); end
            @(posedge clk); #1 md.op = OP_NONE;
            checks += 2;
            if (md.busy !== 1'b0) begin failures++; $display("FAIL nomadd_busy[%0d] got=%b exp=0", o, md.busy); end
            if (md.hi !== m_hi || md.lo !== m_lo) begin
                failures++; $display("FAIL nomadd_hilo[%0d] got=%h:%h exp=%h:%h", o, md.hi, md.lo, m_hi, m_lo);
            end
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        md.op = OP_NONE; md.a = '0; md.b = '0; md.flush = 1'b0;
        reset = 1'b1;
        test_reset();
        test_flush();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
